// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle fill engine.
package rect_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDraw,
    StDone
  } state_e;

  localparam logic [1:0] MODE_SOLID   = 2'b00;
  localparam logic [1:0] MODE_ERASE   = 2'b01;
  localparam logic [1:0] MODE_OUTLINE = 2'b10;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

endpackage

// File: rtl/rect_fill_if.sv
// Request/pixel bundle between a plotting client and the rectangle fill engine.
interface rect_fill_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7,
  parameter int unsigned C_W = 3
) ();
  logic           start;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] w;
  logic [Y_W-1:0] h;
  logic [C_W-1:0] color;
  logic [1:0]     mode;
  logic           pause;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] c_out;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output start, x0, y0, w, h, color, mode, pause,
    input  x_out, y_out, c_out, plot, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, color, mode, pause,
    output x_out, y_out, c_out, plot, busy, done
  );
endinterface

// File: rtl/rect_clip.sv
// Combinational clipping of a requested rectangle against the visible screen.
module rect_clip #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7
) (
  input  logic [X_W-1:0] x0_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] xs_o,
  output logic [X_W-1:0] xe_o,
  output logic [Y_W-1:0] ys_o,
  output logic [Y_W-1:0] ye_o,
  output logic           empty_o
);
  localparam logic [X_W:0] XLast = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] YLast = (Y_W+1)'(SCREEN_H - 1);

  // One extra bit so x0+w-1 never wraps before the clamp.
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  assign x_end = {1'b0, x0_i} + {1'b0, w_i} - (X_W+1)'(1);
  assign y_end = {1'b0, y0_i} + {1'b0, h_i} - (Y_W+1)'(1);

  assign xs_o = x0_i;
  assign ys_o = y0_i;
  assign xe_o = (x_end > XLast) ? XLast[X_W-1:0] : x_end[X_W-1:0];
  assign ye_o = (y_end > YLast) ? YLast[Y_W-1:0] : y_end[Y_W-1:0];

  assign empty_o = (w_i == '0) || (h_i == '0) ||
                   ({1'b0, x0_i} > XLast) || ({1'b0, y0_i} > YLast);
endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: clips a request, then walks it row-major emitting one pixel per cycle.
module rect_fill
  import rect_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned C_W      = 3
) (
  input logic        clk,
  input logic        reset,
  rect_fill_if.slave bus
);
  state_e         state_q, state_d;
  logic [X_W-1:0] x0_q, x0_d, w_q, w_d;
  logic [Y_W-1:0] y0_q, y0_d, h_q, h_d;
  logic [C_W-1:0] c_q, c_d;
  logic           outline_q, outline_d;
  logic [X_W-1:0] xs_q, xs_d, xe_q, xe_d, cur_x_q, cur_x_d;
  logic [Y_W-1:0] ys_q, ys_d, ye_q, ye_d, cur_y_q, cur_y_d;

  logic [X_W-1:0] clip_xs, clip_xe;
  logic [Y_W-1:0] clip_ys, clip_ye;
  logic           clip_empty;

  rect_clip #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_clip (
    .x0_i   (x0_q),
    .w_i    (w_q),
    .y0_i   (y0_q),
    .h_i    (h_q),
    .xs_o   (clip_xs),
    .xe_o   (clip_xe),
    .ys_o   (clip_ys),
    .ye_o   (clip_ye),
    .empty_o(clip_empty)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    c_d       = c_q;
    outline_d = outline_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x0_d      = bus.x0;
          y0_d      = bus.y0;
          w_d       = bus.w;
          h_d       = bus.h;
          c_d       = (bus.mode == MODE_ERASE) ? '0 : bus.color;
          outline_d = (bus.mode == MODE_OUTLINE);
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (clip_empty) begin
          state_d = StDone;
        end else begin
          xs_d    = clip_xs;
          xe_d    = clip_xe;
          ys_d    = clip_ys;
          ye_d    = clip_ye;
          cur_x_d = clip_xs;
          cur_y_d = clip_ys;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (!bus.pause) begin
          if (cur_x_q == xe_q) begin
            if (cur_y_q == ye_q) begin
              state_d = StDone;
            end else begin
              cur_x_d = xs_q;
              cur_y_d = cur_y_q + Y_W'(1);
            end
          end else if (outline_q && (cur_y_q != ys_q) && (cur_y_q != ye_q)) begin
            // Interior outline row: skip straight from the left edge to the right edge.
            cur_x_d = xe_q;
          end else begin
            cur_x_d = cur_x_q + X_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      c_q       <= '0;
      outline_q <= 1'b0;
      xs_q      <= '0;
      xe_q      <= '0;
      ys_q      <= '0;
      ye_q      <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      c_q       <= c_d;
      outline_q <= outline_d;
      xs_q      <= xs_d;
      xe_q      <= xe_d;
      ys_q      <= ys_d;
      ye_q      <= ye_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
    end
  end

  assign bus.x_out = cur_x_q;
  assign bus.y_out = cur_y_q;
  assign bus.c_out = c_q;
  assign bus.plot  = (state_q == StDraw) && !bus.pause;
  assign bus.busy  = (state_q == StSetup) || (state_q == StDraw);
  assign bus.done  = (state_q == StDone);
endmodule

// File: tb/tb_rect_fill.sv
// Randomised and directed bench for rect_fill against a pixel-list reference model.
module tb_rect_fill;
  logic clk = 1'b0;
  logic reset = 1'b0;

  rect_fill_if #(.X_W(8), .Y_W(7), .C_W(3)) bus ();

  rect_fill #(
    .SCREEN_W(160),
    .SCREEN_H(120),
    .X_W     (8),
    .Y_W     (7),
    .C_W     (3)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} pix_t;
  typedef enum {MIdle, MSetup, MDraw, MDone} mph_e;

  pix_t exp_q[$];
  pix_t seen_q[$];
  mph_e ph = MIdle;
  int   errors = 0, checks = 0;
  int   cyc = 0, acc_cyc = 0, lat = 0, done_cnt = 0, busy_cyc = 0;
  bit   ep;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixel list, straight from the clip and outline rules.
  function automatic void build(input int x0, input int y0, input int w, input int h,
                                input int c, input int md);
    int xe, ye, col;
    pix_t p;
    exp_q.delete();
    if (w == 0 || h == 0 || x0 >= 160 || y0 >= 120) return;
    xe  = (x0 + w - 1 > 159) ? 159 : x0 + w - 1;
    ye  = (y0 + h - 1 > 119) ? 119 : y0 + h - 1;
    col = (md == 1) ? 0 : c;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        if (md != 2 || y == y0 || y == ye || x == x0 || x == xe) begin
          p.x = x; p.y = y; p.c = col;
          exp_q.push_back(p);
        end
  endfunction

  function automatic int sx(input int i);
    return (i < seen_q.size()) ? seen_q[i].x : -1;
  endfunction
  function automatic int sy(input int i);
    return (i < seen_q.size()) ? seen_q[i].y : -1;
  endfunction
  function automatic int sc(input int i);
    return (i < seen_q.size()) ? seen_q[i].c : -1;
  endfunction

  // Model phase advance on each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      ph = MIdle;
      exp_q.delete();
    end else begin
      case (ph)
        MIdle: if (bus.start) begin
          build(bus.x0, bus.y0, bus.w, bus.h, bus.color, bus.mode);
          seen_q.delete();
          busy_cyc = 0;
          acc_cyc  = cyc;
          ph       = MSetup;
        end
        MSetup: ph = (exp_q.size() == 0) ? MDone : MDraw;
        MDraw: if (!bus.pause) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) ph = MDone;
        end
        MDone: ph = MIdle;
        default: ph = MIdle;
      endcase
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    ep = (ph == MDraw) && !bus.pause;
    chk("plot", bus.plot, ep);
    chk("busy", bus.busy, (ph == MSetup || ph == MDraw));
    chk("done", bus.done, ph == MDone);
    if (bus.plot && ep && exp_q.size() > 0) begin
      chk("pix_x", bus.x_out, exp_q[0].x);
      chk("pix_y", bus.y_out, exp_q[0].y);
      chk("pix_c", bus.c_out, exp_q[0].c);
      seen_q.push_back('{x: int'(bus.x_out), y: int'(bus.y_out), c: int'(bus.c_out)});
    end
    if (bus.busy) busy_cyc++;
    if (bus.done) begin
      lat = cyc - acc_cyc + 1;
      done_cnt++;
    end
  end

  task automatic run_job(input int x0, input int y0, input int w, input int h, input int c,
                         input int md, input int pct, input int pause_at);
    int d0, k;
    @(posedge clk); #1;
    bus.x0 = 8'(x0); bus.y0 = 7'(y0); bus.w = 8'(w); bus.h = 7'(h);
    bus.color = 3'(c); bus.mode = 2'(md); bus.pause = 1'b0; bus.start = 1'b1;
    d0 = done_cnt;
    k  = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (done_cnt == d0 && k < 3000) begin
      k++;
      bus.pause = (pause_at >= 0 && k >= pause_at && k < pause_at + 3) ||
                  ($urandom_range(99) < pct);
      // Stray starts while busy must be ignored.
      bus.start = (pct > 0) && ($urandom_range(9) == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    if (done_cnt == d0) chk("job_timeout", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.w = '0; bus.h = '0; bus.color = '0; bus.mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", bus.x_out, 0); chk("rst_y", bus.y_out, 0); chk("rst_c", bus.c_out, 0);
    chk("rst_plot", bus.plot, 0); chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0);
    reset = 1'b1;

    run_job(10, 5, 3, 2, 5, 0, 0, -1);
    chk("solid_lat", lat, 8);
    chk("solid_n", seen_q.size(), 6);
    chk("solid_busy", busy_cyc, 7);
    chk("solid_p0x", sx(0), 10); chk("solid_p0y", sy(0), 5);
    chk("solid_p3x", sx(3), 10); chk("solid_p3y", sy(3), 6);
    chk("solid_p5x", sx(5), 12); chk("solid_p5c", sc(5), 5);

    run_job(158, 118, 5, 5, 1, 0, 0, -1);
    chk("clip_n", seen_q.size(), 4);
    chk("clip_lat", lat, 6);
    chk("clip_p3x", sx(3), 159); chk("clip_p3y", sy(3), 119);

    run_job(0, 0, 4, 3, 6, 2, 0, -1);
    chk("outl_n", seen_q.size(), 10);
    chk("outl_p4x", sx(4), 0); chk("outl_p4y", sy(4), 1);
    chk("outl_p5x", sx(5), 3); chk("outl_p5y", sy(5), 1);
    chk("outl_lat", lat, 12);

    run_job(0, 0, 4, 3, 7, 1, 0, -1);
    chk("erase_n", seen_q.size(), 12);
    chk("erase_c", sc(11), 0);

    run_job(159, 10, 5, 4, 2, 2, 0, -1);
    chk("outl_w1_n", seen_q.size(), 4);
    run_job(10, 10, 5, 1, 2, 2, 0, -1);
    chk("outl_h1_n", seen_q.size(), 5);

    run_job(5, 5, 0, 4, 3, 0, 0, -1);
    chk("empty_w_n", seen_q.size(), 0);
    chk("empty_w_lat", lat, 2);
    chk("empty_w_busy", busy_cyc, 1);
    run_job(200, 5, 4, 4, 3, 0, 0, -1);
    chk("empty_x_n", seen_q.size(), 0);
    chk("empty_x_lat", lat, 2);

    run_job(20, 20, 2, 2, 4, 0, 0, 2);
    chk("pause_lat", lat, 9);
    chk("pause_n", seen_q.size(), 4);
    chk("pause_p1x", sx(1), 21); chk("pause_p2y", sy(2), 21);

    @(posedge clk); #1;
    bus.x0 = 8'd30; bus.y0 = 7'd30; bus.w = 8'd40; bus.h = 7'd10;
    bus.color = 3'd3; bus.mode = 2'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("busy_ignore", bus.busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_x", bus.x_out, 0); chk("mid_y", bus.y_out, 0); chk("mid_c", bus.c_out, 0);
    chk("mid_plot", bus.plot, 0); chk("mid_busy", bus.busy, 0); chk("mid_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    run_job(30, 30, 3, 3, 2, 0, 0, -1);
    chk("after_rst_n", seen_q.size(), 9);
    chk("after_rst_lat", lat, 11);

    for (int j = 0; j < 30; j++) begin
      run_job($urandom_range(175), $urandom_range(130), $urandom_range(24),
              $urandom_range(24), $urandom_range(7), $urandom_range(3), 20, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
